// File: rtl/fastserial_tx_arbiter_pkg.sv
// Shared types and constants for the FastSerial TX arbiter.
// Holds the FSM state encoding and the default timing parameters.
package fastserial_tx_arbiter_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_HOLDOFF = 2;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

endpackage

// File: rtl/fastserial_tx_arbiter_rr.sv
// Two-input round-robin grant with a last-granted register.
// When both request, the one not granted last wins; otherwise the single requester wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] grant
);

    logic last;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= owner;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fastserial_tx_arbiter.sv
// Packet-granular arbiter sharing one serial TX byte stream between two requesters.
// Each write is followed by a holdoff window that masks the transmitter busy latency.
module fastserial_tx_arbiter
    import fastserial_tx_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_valid,
    input  logic [BYTE_W-1:0] i_req0_data,
    input  logic              i_req0_last,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [BYTE_W-1:0] i_req1_data,
    input  logic              i_req1_last,
    output logic              o_req1_ready,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_write,
    input  logic              i_tx_busy,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ?
                             TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t ONE       = cnt_t'(1);
    localparam cnt_t CNT_SAT   = cnt_t'(CNT_MAX);
    localparam cnt_t TO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);
    localparam cnt_t HOLD_LOAD = cnt_t'(HOLDOFF_CYCLES);

    state_t            state, state_n;
    logic [1:0]        owner, owner_n;
    cnt_t              cnt, cnt_n;
    logic              last_flag, last_flag_n;
    logic [BYTE_W-1:0] tx_data_n;
    logic              tx_write_n, timeout_n;
    logic [1:0]        arb_grant;
    logic              rr_update;
    logic              own_valid, own_last, xfer;
    logic [BYTE_W-1:0] own_data;

    rr_arbiter2 u_rr (
        .clk    (i_clk),
        .reset  (i_reset),
        .req    ({i_req1_valid, i_req0_valid}),
        .update (rr_update),
        .owner  (owner[1]),
        .grant  (arb_grant)
    );

    assign own_valid = owner[1] ? i_req1_valid : i_req0_valid;
    assign own_last  = owner[1] ? i_req1_last  : i_req0_last;
    assign own_data  = owner[1] ? i_req1_data  : i_req0_data;

    assign o_req0_ready = (state == SEND) && owner[0] && !i_tx_busy;
    assign o_req1_ready = (state == SEND) && owner[1] && !i_tx_busy;
    assign xfer         = (o_req0_ready && i_req0_valid) ||
                          (o_req1_ready && i_req1_valid);
    assign o_grant      = owner;

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        cnt_n       = cnt;
        last_flag_n = last_flag;
        tx_data_n   = o_tx_data;
        tx_write_n  = 1'b0;
        timeout_n   = 1'b0;
        rr_update   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (i_req0_valid || i_req1_valid) begin
                    owner_n = arb_grant;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_data_n   = own_data;
                    tx_write_n  = 1'b1;
                    last_flag_n = own_last;
                    cnt_n       = HOLD_LOAD;
                    state_n     = HOLD;
                end else if (own_valid) begin
                    // a stalled transmitter is not an idle requester
                    cnt_n = '0;
                end else if (cnt == TO_LAST) begin
                    timeout_n = 1'b1;
                    rr_update = 1'b1;
                    owner_n   = '0;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (cnt != CNT_SAT) begin
                    cnt_n = cnt + ONE;
                end
            end
            HOLD: begin
                // zero or one both mean this is the final holdoff cycle
                if (cnt <= ONE) begin
                    cnt_n = '0;
                    if (last_flag) begin
                        rr_update = 1'b1;
                        owner_n   = '0;
                        state_n   = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            owner      <= '0;
            cnt        <= '0;
            last_flag  <= 1'b0;
            o_tx_data  <= '0;
            o_tx_write <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            cnt        <= cnt_n;
            last_flag  <= last_flag_n;
            o_tx_data  <= tx_data_n;
            o_tx_write <= tx_write_n;
            o_timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_fastserial_tx_arbiter.sv
// Self-checking bench for the FastSerial TX arbiter.
// Vector table, directed corner sequences and a randomized run against a rule model.
module tb_fastserial_tx_arbiter;

    localparam int TO = 16;
    localparam int HO = 2;
    localparam int HP = (HO == 0) ? 1 : HO;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, l0, v1, l1, busy;
    logic [7:0] d0, d1;
    logic       r0, r1, wr, tmo;
    logic [7:0] txd;
    logic [1:0] gnt;

    always #5 clk = ~clk;

    fastserial_tx_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req0_valid (v0),
        .i_req0_data  (d0),
        .i_req0_last  (l0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_data  (d1),
        .i_req1_last  (l1),
        .o_req1_ready (r1),
        .o_tx_data    (txd),
        .o_tx_write   (wr),
        .i_tx_busy    (busy),
        .o_grant      (gnt),
        .o_timeout    (tmo)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // requester drivers: queues of {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit drv = 0, rnd = 0, g0 = 1, g1 = 1;
    int st0 = 0, st1 = 0, bst = 0;

    int wlog[$];
    int wcyc[$];
    int acyc[$];
    int tcyc[$];

    logic       s_r0, s_r1, s_wr;
    logic [7:0] s_data;
    logic [1:0] s_gnt;

    // rule model: owner, cycles since acceptance, idle run, last-granted
    int         m_owner = -1, m_last = 1, m_since = 0, m_idle = 0;
    bit         m_lf = 0, m_wr = 0, m_to = 0;
    logic [7:0] m_data = 8'h00;

    task automatic monitor();
        bit send, er0, er1, vo, lo;
        logic [7:0] dd;
        send = (m_owner >= 0) && (m_since > HP);
        er0  = send && (m_owner == 0) && !busy;
        er1  = send && (m_owner == 1) && !busy;
        chk("grant", int'(gnt), (m_owner < 0) ? 0 : ((m_owner == 0) ? 1 : 2));
        chk("timeout", int'(tmo), int'(m_to));
        chk("ready0", int'(r0), int'(er0));
        chk("ready1", int'(r1), int'(er1));
        chk("write", int'(wr), int'(m_wr));
        chk("data", int'(txd), int'(m_data));
        m_wr = 0;
        m_to = 0;
        if (rst) begin
            m_owner = -1;
            m_last  = 1;
            m_data  = 8'h00;
            m_idle  = 0;
            return;
        end
        vo = (m_owner == 1) ? v1 : v0;
        lo = (m_owner == 1) ? l1 : l0;
        dd = (m_owner == 1) ? d1 : d0;
        if (m_owner < 0) begin
            if (v0 || v1) begin
                m_owner = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v0 ? 0 : 1);
                m_since = HP + 1;
                m_idle  = 0;
            end
        end else if (send) begin
            if (vo && !busy) begin
                m_wr    = 1;
                m_data  = dd;
                m_lf    = lo;
                m_since = 1;
            end else begin
                m_idle = vo ? 0 : m_idle + 1;
                if (m_idle == TO) begin
                    m_to    = 1;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_idle  = 0;
                end
            end
        end else if (m_since == HP) begin
            if (m_lf) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_since = HP + 1;
                m_idle  = 0;
            end
        end else begin
            m_since++;
        end
    endtask

    task automatic drive();
        v0 = (q0.size() > 0) && g0;
        v1 = (q1.size() > 0) && g1;
        {l0, d0} = v0 ? q0[0] : 9'h000;
        {l1, d1} = v1 ? q1[0] : 9'h000;
    endtask

    task automatic push_pkt(input int n, input int len);
        for (int k = 0; k < len; k++) begin
            logic [8:0] e;
            e = {k == len - 1, 8'($urandom_range(0, 255))};
            if (n == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic step();
        bit a0, a1;
        @(negedge clk);
        a0     = v0 && r0;
        a1     = v1 && r1;
        s_r0   = r0;
        s_r1   = r1;
        s_wr   = wr;
        s_data = txd;
        s_gnt  = gnt;
        monitor();
        if (wr)       begin wlog.push_back(int'(txd)); wcyc.push_back(cyc); end
        if (tmo)      tcyc.push_back(cyc);
        if (a0 || a1) acyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (drv) begin
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            if (rnd) begin
                if (st0 > 0) st0--;
                else if ($urandom_range(0, 199) == 0) st0 = $urandom_range(10, 25);
                if (st1 > 0) st1--;
                else if ($urandom_range(0, 199) == 0) st1 = $urandom_range(10, 25);
                g0 = (st0 == 0) && ($urandom_range(0, 7) != 0);
                g1 = (st1 == 0) && ($urandom_range(0, 7) != 0);
                if (bst > 0) bst--;
                else if ($urandom_range(0, 29) == 0) bst = $urandom_range(1, 12);
                busy = (bst > 0) || ($urandom_range(0, 4) == 0);
                if (q0.size() < 2) push_pkt(0, $urandom_range(1, 4));
                if (q1.size() < 2) push_pkt(1, $urandom_range(1, 4));
                rst = ($urandom_range(0, 1999) == 0);
            end
            drive();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        busy = 1'b0;
        g0   = 1;
        g1   = 1;
        q0.delete();
        q1.delete();
        v0 = 0; d0 = 8'h00; l0 = 0;
        v1 = 0; d1 = 8'h00; l1 = 0;
        step();
        step();
        rst = 1'b0;
        wlog.delete();
        wcyc.delete();
        acyc.delete();
        tcyc.delete();
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       busy;
        logic       r0;
        logic       r1;
        logic       wr;
        logic [7:0] data;
        logic [1:0] gnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, cb, ca;

        // three-byte packet from requester 0, writes spaced by holdoff+1
        tbl[0]  = '{1, 8'hA1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 2'b00};
        tbl[1]  = '{1, 8'hA1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 2'b01};
        tbl[2]  = '{1, 8'hA2, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA1, 2'b01};
        tbl[3]  = '{1, 8'hA2, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA1, 2'b01};
        tbl[4]  = '{1, 8'hA2, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA1, 2'b01};
        tbl[5]  = '{1, 8'hA3, 1, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA2, 2'b01};
        tbl[6]  = '{1, 8'hA3, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA2, 2'b01};
        tbl[7]  = '{1, 8'hA3, 1, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA2, 2'b01};
        tbl[8]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA3, 2'b01};
        tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA3, 2'b01};
        tbl[10] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA3, 2'b00};

        drv = 0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            v0 = tbl[i].v0; d0 = tbl[i].d0; l0 = tbl[i].l0;
            v1 = tbl[i].v1; d1 = tbl[i].d1; l1 = tbl[i].l1;
            busy = tbl[i].busy;
            step();
            chk($sformatf("tbl%0d_ready0", i), int'(s_r0), int'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), int'(s_r1), int'(tbl[i].r1));
            chk($sformatf("tbl%0d_write", i), int'(s_wr), int'(tbl[i].wr));
            chk($sformatf("tbl%0d_data", i), int'(s_data), int'(tbl[i].data));
            chk($sformatf("tbl%0d_grant", i), int'(s_gnt), int'(tbl[i].gnt));
        end

        // contention from reset, then a second contention
        drv = 1;
        do_reset();
        q0.push_back(9'h010); q0.push_back(9'h111);
        q1.push_back(9'h120);
        drive();
        run(30);
        chk("rr_count", wlog.size(), 3);
        chk("rr_b0", (wlog.size() > 0) ? wlog[0] : -1, 'h10);
        chk("rr_b1", (wlog.size() > 1) ? wlog[1] : -1, 'h11);
        chk("rr_b2", (wlog.size() > 2) ? wlog[2] : -1, 'h20);
        q0.push_back(9'h130);
        q1.push_back(9'h140);
        drive();
        run(20);
        chk("rr2_b0", (wlog.size() > 3) ? wlog[3] : -1, 'h30);
        chk("rr2_b1", (wlog.size() > 4) ? wlog[4] : -1, 'h40);

        // long transmitter stall with valid held high
        do_reset();
        busy = 1'b1;
        q0.push_back(9'h177);
        drive();
        run(50);
        chk("busy_nowrite", wlog.size(), 0);
        chk("busy_notimeout", tcyc.size(), 0);
        busy = 1'b0;
        cb   = cyc;
        run(6);
        chk("busy_wcount", wlog.size(), 1);
        chk("busy_wcyc", (wcyc.size() > 0) ? wcyc[0] : -1, cb + 1);

        // mid-packet timeout, then requester 0 wins
        do_reset();
        q1.push_back(9'h055);
        drive();
        run(40);
        ca = (acyc.size() > 0) ? acyc[0] : -100;
        chk("to_count", tcyc.size(), 1);
        chk("to_cyc", (tcyc.size() > 0) ? tcyc[0] : -1, ca + HP + 1 + TO);
        chk("to_grant", int'(s_gnt), 0);
        q0.push_back(9'h166);
        q1.push_back(9'h156);
        drive();
        run(20);
        chk("to_next0", (wlog.size() > 1) ? wlog[1] : -1, 'h66);
        chk("to_next1", (wlog.size() > 2) ? wlog[2] : -1, 'h56);

        // reset after byte 2 of a 4-byte packet
        do_reset();
        q0.push_back(9'h081); q0.push_back(9'h082);
        q0.push_back(9'h083); q0.push_back(9'h184);
        drive();
        for (int i = 0; i < 40 && wlog.size() < 2; i++) step();
        chk("rst_progress", wlog.size(), 2);
        q0.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive();
        n = wlog.size();
        step();
        chk("rst_write", int'(s_wr), 0);
        chk("rst_grant", int'(s_gnt), 0);
        chk("rst_data", int'(s_data), 0);
        run(5);
        chk("rst_nowrite", wlog.size(), n);
        q0.push_back(9'h191);
        drive();
        run(15);
        chk("rst_newpkt", wlog.size(), n + 1);
        chk("rst_newbyte", (wlog.size() > n) ? wlog[n] : -1, 'h91);

        // randomized traffic against the rule model
        do_reset();
        rnd = 1;
        run(10000);
        rnd = 0;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
